// File: rtl/id_ctrl_seq.sv
// id_ctrl_seq
//   Registered decode-and-issue controller between the IF/ID and ID/EX
//   registers of a 5-stage MIPS pipeline. It decodes opcode/func into the EX
//   control word and registers it. A small sequencer tracks the multi-cycle
//   MULT/MULTU/DIV/DIVU unit and interlocks HI/LO users (mul/div, mfhi, mflo)
//   while that unit is busy.
//
// Ports
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   instr_valid_i     ID holds a real instruction
//   opcode_i, func_i  instr[31:26], instr[5:0]
//   hold_i            downstream stall: control register holds, no md issue
//   flush_i           kill the ID instruction (loads a bubble)
//   RegDst_o .. hilo_rd_o   registered EX control word
//   md_start_o/md_op_o      one-cycle start pulse and op code to mul/div unit
//   md_busy_o         sequencer not IDLE
//   stall_o           combinational freeze of PC and IF/ID
//   illegal_o         registered flag for an undecodable valid instruction
module id_ctrl_seq #(
  parameter int ALU_OP_W = 3,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid_i,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          func_i,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic [1:0]          RegDst_o,
  output logic                DataC_o,
  output logic                RegWrite_o,
  output logic                Branch_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                imm_en_o,
  output logic [1:0]          PCSrc_o,
  output logic [ALU_OP_W-1:0] AluOperation_o,
  output logic [1:0]          hilo_rd_o,
  output logic                md_start_o,
  output logic [1:0]          md_op_o,
  output logic                md_busy_o,
  output logic                stall_o,
  output logic                illegal_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_LAT - 1);
  // A one-cycle unit never leaves IDLE.
  localparam bit MUL_MC = (MUL_LAT > 1);
  localparam bit DIV_MC = (DIV_LAT > 1);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

  typedef struct packed {
    logic [1:0]          reg_dst;
    logic                data_c;
    logic                reg_write;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                imm_en;
    logic [1:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          hilo_rd;
  } ctrl_t;

  ctrl_t          dec;
  logic           dec_illegal;
  logic           dec_md;      // mult/multu/div/divu
  logic           dec_hilo;    // needs the mul/div unit idle (md op, mfhi, mflo)
  state_t         state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic           busy;
  logic           stall;
  logic           issued;
  logic           md_issue;
  ctrl_t          ctrl_q;
  logic           illegal_q;
  logic           md_start_q;
  logic [1:0]     md_op_q;

  // ---------------------------------------------------------------- decode
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    dec_hilo    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (func_i)
          FN_JR: dec.pc_src = 2'd2;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            dec_md   = 1'b1;
            dec_hilo = 1'b1;
          end
          FN_MFHI: begin
            dec.reg_write = 1'b1;
            dec.hilo_rd   = 2'd1;
            dec_hilo      = 1'b1;
          end
          FN_MFLO: begin
            dec.reg_write = 1'b1;
            dec.hilo_rd   = 2'd2;
            dec_hilo      = 1'b1;
          end
          FN_SUB: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALU_OP_W'(3'd3);
          end
          FN_SLT: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALU_OP_W'(3'd4);
          end
          default: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALU_OP_W'(func_i[2:0]);
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'd1;
        dec.imm_en    = 1'b1;
        dec.alu_op    = ALU_OP_W'(3'd2);
      end
      OP_SLTI: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'd1;
        dec.imm_en    = 1'b1;
        dec.alu_op    = ALU_OP_W'(3'd4);
      end
      OP_LW: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'd1;
        dec.imm_en    = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_op    = ALU_OP_W'(3'd2);
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.imm_en    = 1'b1;
        dec.alu_op    = ALU_OP_W'(3'd2);
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_OP_W'(3'd3);
      end
      OP_J: dec.pc_src = 2'd1;
      OP_JAL: begin
        dec.pc_src    = 2'd1;
        dec.reg_dst   = 2'd2;
        dec.data_c    = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ------------------------------------------------------ sequencer: state
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // ------------------------------------------------- sequencer: next state
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_issue) begin
          // func[1] separates div/divu from mult/multu.
          if (func_i[1]) begin
            if (DIV_MC) begin
              state_nxt = DIV_BUSY;
              cnt_nxt   = DIV_CNT0;
            end
          end else if (MUL_MC) begin
            state_nxt = MUL_BUSY;
            cnt_nxt   = MUL_CNT0;
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (cnt_q == '0) state_nxt = IDLE;
        else             cnt_nxt   = cnt_q - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ----------------------------------------------------- sequencer: outputs
  // Flush wins over the interlock: a killed instruction never needs to wait.
  always_comb begin
    busy  = (state_q != IDLE);
    stall = busy & instr_valid_i & dec_hilo & ~flush_i;
  end

  assign issued   = instr_valid_i & ~flush_i & ~stall & ~hold_i;
  assign md_issue = issued & dec_md;

  // ------------------------------------------------------ control register
  // Anything not issued (invalid, flushed, stalled) loads a bubble; hold
  // freezes the word but must not repeat the start pulse.
  // NOTE: only pipeline control registers are reset here; there is no memory
  // array in this block that would need to be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
      md_op_q    <= 2'd0;
    end else if (hold_i) begin
      md_start_q <= 1'b0;
    end else if (issued) begin
      ctrl_q     <= dec;
      illegal_q  <= dec_illegal;
      md_start_q <= dec_md;
      md_op_q    <= dec_md ? func_i[1:0] : 2'd0;
    end else begin
      ctrl_q     <= '0;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
      md_op_q    <= 2'd0;
    end
  end

  assign RegDst_o       = ctrl_q.reg_dst;
  assign DataC_o        = ctrl_q.data_c;
  assign RegWrite_o     = ctrl_q.reg_write;
  assign Branch_o       = ctrl_q.branch;
  assign MemRead_o      = ctrl_q.mem_read;
  assign MemWrite_o     = ctrl_q.mem_write;
  assign imm_en_o       = ctrl_q.imm_en;
  assign PCSrc_o        = ctrl_q.pc_src;
  assign AluOperation_o = ctrl_q.alu_op;
  assign hilo_rd_o      = ctrl_q.hilo_rd;
  assign md_start_o     = md_start_q;
  assign md_op_o        = md_op_q;
  assign md_busy_o      = busy;
  assign stall_o        = stall;
  assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_id_ctrl_seq.sv
// Directed bench for id_ctrl_seq (MUL_LAT=4, DIV_LAT=32). Each step drives
// one ID-stage instruction, checks the combinational stall, pushes the
// expected EX word to a scoreboard queue and pops/compares it after the edge.
module tb_id_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       hold;
  logic       flush;
  logic [1:0] reg_dst;
  logic       data_c, reg_write, branch, mem_read, mem_write, imm_en;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic [1:0] hilo_rd;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy, stall, illegal;

  always #5 clk = ~clk;

  id_ctrl_seq #(.ALU_OP_W(3), .MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid),
    .opcode_i(opcode), .func_i(func), .hold_i(hold), .flush_i(flush),
    .RegDst_o(reg_dst), .DataC_o(data_c), .RegWrite_o(reg_write),
    .Branch_o(branch), .MemRead_o(mem_read), .MemWrite_o(mem_write),
    .imm_en_o(imm_en), .PCSrc_o(pc_src), .AluOperation_o(alu_op),
    .hilo_rd_o(hilo_rd), .md_start_o(md_start), .md_op_o(md_op),
    .md_busy_o(md_busy), .stall_o(stall), .illegal_o(illegal)
  );

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       data_c, reg_write, branch, mem_read, mem_write, imm_en;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] hilo_rd;
    logic       md_start;
    logic [1:0] md_op;
    logic       illegal;
  } out_t;

  localparam out_t BUB = '0;

  out_t exp_q[$];
  out_t last_exp = '0;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  // {opcode, func} pairs for the decode sweep
  localparam logic [11:0] SWEEP [12] = '{
    {6'b101011, 6'b000000}, {6'b000100, 6'b000000}, {6'b000010, 6'b000000},
    {6'b001000, 6'b000000}, {6'b001001, 6'b000000}, {6'b001010, 6'b000000},
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b101010},
    {6'b000000, 6'b100101}, {6'b000000, 6'b001000}, {6'b000000, 6'b010000}
  };

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic out_t observed();
    out_t o;
    o = '{reg_dst, data_c, reg_write, branch, mem_read, mem_write, imm_en,
          pc_src, alu_op, hilo_rd, md_start, md_op, illegal};
    return o;
  endfunction

  // md_op carries meaning only alongside md_start.
  function automatic out_t masked(input out_t v);
    out_t r;
    r = v;
    if (!r.md_start) r.md_op = 2'd0;
    return r;
  endfunction

  // Expected EX word of an issued instruction, from the decode table.
  function automatic out_t dec(input logic [5:0] op, input logic [5:0] fn);
    out_t o;
    o = '0;
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) o.pc_src = 2'd2;
        else if (fn[5:2] == 4'b0110) begin
          o.md_start = 1'b1;
          o.md_op    = fn[1:0];
        end else if (fn == 6'b010000) begin
          o.reg_write = 1'b1; o.hilo_rd = 2'd1;
        end else if (fn == 6'b010010) begin
          o.reg_write = 1'b1; o.hilo_rd = 2'd2;
        end else begin
          o.reg_write = 1'b1;
          if (fn == 6'b100010)      o.alu_op = 3'd3;
          else if (fn == 6'b101010) o.alu_op = 3'd4;
          else                      o.alu_op = fn[2:0];
        end
      end
      6'b001000, 6'b001001: begin
        o.reg_write = 1'b1; o.reg_dst = 2'd1; o.imm_en = 1'b1; o.alu_op = 3'd2;
      end
      6'b001010: begin
        o.reg_write = 1'b1; o.reg_dst = 2'd1; o.imm_en = 1'b1; o.alu_op = 3'd4;
      end
      6'b100011: begin
        o.reg_write = 1'b1; o.reg_dst = 2'd1; o.imm_en = 1'b1;
        o.mem_read = 1'b1;  o.alu_op = 3'd2;
      end
      6'b101011: begin
        o.mem_write = 1'b1; o.imm_en = 1'b1; o.alu_op = 3'd2;
      end
      6'b000100: begin
        o.branch = 1'b1; o.alu_op = 3'd3;
      end
      6'b000010: o.pc_src = 2'd1;
      6'b000011: begin
        o.pc_src = 2'd1; o.reg_dst = 2'd2; o.data_c = 1'b1; o.reg_write = 1'b1;
      end
      default: o.illegal = 1'b1;
    endcase
    return o;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input string tag, input logic v, input logic [5:0] op,
                      input logic [5:0] fn, input logic h, input logic f,
                      input logic exp_stall, input out_t exp,
                      input logic exp_busy);
    out_t e;
    out_t got;
    instr_valid = v; opcode = op; func = fn; hold = h; flush = f;
    #1;
    check({tag, " stall"}, 32'(stall), 32'(exp_stall));
    if (h) begin
      e = last_exp;
      e.md_start = 1'b0;
    end else begin
      e = exp;
    end
    last_exp = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, " word"}, 32'(masked(observed())), 32'(masked(got)));
    check({tag, " busy"}, 32'(md_busy), 32'(exp_busy));
  endtask

  task automatic nop(input string tag, input logic exp_busy);
    step(tag, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, BUB, exp_busy);
  endtask

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;

  initial begin
    out_t e;
    logic [11:0] ent;
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; func = '0;
    hold = 1'b0; flush = 1'b0;
    #1;
    check("reset word", 32'(observed()), 32'(BUB));
    check("reset busy", 32'(md_busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // lw and jal with literal expectations
    e = '0; e.reg_write = 1'b1; e.reg_dst = 2'd1; e.mem_read = 1'b1;
    e.imm_en = 1'b1; e.alu_op = 3'd2;
    step("lw", 1'b1, 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e, 1'b0);
    e = '0; e.pc_src = 2'd1; e.reg_dst = 2'd2; e.data_c = 1'b1;
    e.reg_write = 1'b1;
    step("jal", 1'b1, 6'b000011, 6'd0, 1'b0, 1'b0, 1'b0, e, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ent = SWEEP[i];
      step($sformatf("sweep%0d", i), 1'b1, ent[11:6], ent[5:0], 1'b0, 1'b0,
           1'b0, dec(ent[11:6], ent[5:0]), 1'b0);
    end

    // illegal opcode, then a bubble clears the flag
    e = '0; e.illegal = 1'b1;
    step("illegal", 1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, 1'b0, e, 1'b0);
    nop("after_illegal", 1'b0);

    // mult then mflo back-to-back: 4 stall cycles
    e = '0; e.md_start = 1'b1; e.md_op = 2'd0;
    step("mult", 1'b1, R, MULT, 1'b0, 1'b0, 1'b0, e, 1'b1);
    for (int i = 0; i < 4; i++)
      step($sformatf("mflo_stall%0d", i), 1'b1, R, MFLO, 1'b0, 1'b0, 1'b1,
           BUB, (i < 3));
    e = '0; e.reg_write = 1'b1; e.hilo_rd = 2'd2;
    step("mflo_issue", 1'b1, R, MFLO, 1'b0, 1'b0, 1'b0, e, 1'b0);

    // div, independent add, then mfhi waits for the unit
    e = '0; e.md_start = 1'b1; e.md_op = 2'd2;
    step("div", 1'b1, R, DIV, 1'b0, 1'b0, 1'b0, e, 1'b1);
    step("add_busy", 1'b1, R, 6'b100000, 1'b0, 1'b0, 1'b0,
         dec(R, 6'b100000), 1'b1);
    for (int i = 0; i < 31; i++)
      step($sformatf("mfhi_stall%0d", i), 1'b1, R, MFHI, 1'b0, 1'b0, 1'b1,
           BUB, (i < 30));
    e = '0; e.reg_write = 1'b1; e.hilo_rd = 2'd1;
    step("mfhi_issue", 1'b1, R, MFHI, 1'b0, 1'b0, 1'b0, e, 1'b0);

    // flush beats the interlock; in-flight mult still completes
    e = '0; e.md_start = 1'b1; e.md_op = 2'd0;
    step("mult2", 1'b1, R, MULT, 1'b0, 1'b0, 1'b0, e, 1'b1);
    step("mfhi_flush", 1'b1, R, MFHI, 1'b0, 1'b1, 1'b0, BUB, 1'b1);
    for (int i = 0; i < 3; i++)
      nop($sformatf("mult2_drain%0d", i), (i < 2));

    // hold during DIV_BUSY: word frozen, counter keeps running
    e = '0; e.md_start = 1'b1; e.md_op = 2'd3;
    step("divu", 1'b1, R, 6'b011011, 1'b0, 1'b0, 1'b0, e, 1'b1);
    step("addi_busy", 1'b1, 6'b001000, 6'd0, 1'b0, 1'b0, 1'b0,
         dec(6'b001000, 6'd0), 1'b1);
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 1'b1, 6'b100011, 6'd0, 1'b1, 1'b0, 1'b0,
           BUB, 1'b1);
    for (int i = 0; i < 28; i++)
      nop($sformatf("divu_drain%0d", i), (i < 27));

    // asynchronous reset mid MUL_BUSY
    e = '0; e.md_start = 1'b1; e.md_op = 2'd1;
    step("multu", 1'b1, R, 6'b011001, 1'b0, 1'b0, 1'b0, e, 1'b1);
    instr_valid = 1'b1; opcode = R; func = MFHI;
    #1;
    check("pre_reset stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset word", 32'(observed()), 32'(BUB));
    check("async_reset busy", 32'(md_busy), 32'd0);
    check("async_reset stall", 32'(stall), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    instr_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ctrl_seq.md
# id_ctrl_seq

Registered decode-and-issue controller for the 5-stage MIPS pipeline, sitting between the IF/ID register and the ID/EX register. It decodes opcode/func into the pipeline control word, registers it into EX, and adds a multi-cycle sequencer for MULT/MULTU/DIV/DIVU with HI/LO interlock stalls. It also flags illegal encodings and supports flush/hold from hazard logic.

## Interface
- ALU_OP_W, 3: AluOperation width (>=3); codes zero-extended.
- MUL_LAT, 4: multiply busy cycles (>=1).
- DIV_LAT, 32: divide busy cycles (>=1).
- CNT_W, 6: busy counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- instr_valid_i  in  1  ID holds a real instruction.
- opcode_i  in  6  instr[31:26].
- func_i  in  6  instr[5:0].
- hold_i  in  1  downstream stall; control register holds.
- flush_i  in  1  kill the ID instruction (branch/jump taken).
- RegDst_o  out  2  0 rd, 1 rt, 2 $ra.
- DataC_o  out  1  write-back selects PC+4 (jal).
- RegWrite_o, Branch_o, MemRead_o, MemWrite_o, imm_en_o  out  1 each.
- PCSrc_o  out  2  0 PC+4, 1 jump target, 2 register (jr).
- AluOperation_o  out  ALU_OP_W  ALU code.
- hilo_rd_o  out  2  0 none, 1 mfhi, 2 mflo.
- md_start_o  out  1  one-cycle start pulse to mul/div unit.
- md_op_o  out  2  0 mult, 1 multu, 2 div, 3 divu; valid with md_start_o.
- md_busy_o  out  1  sequencer not IDLE.
- stall_o  out  1  combinational; freeze PC and IF/ID.
- illegal_o  out  1  registered; undecodable valid instruction.

## Operation
- Decode (opcode/func): R-type 000000 -> RegWrite, RegDst=0, AluOp=func[2:0], sub(100010)->3, slt(101010)->4; addi 001000/addiu 001001 -> RegWrite, RegDst=1, imm_en, AluOp=2; slti 001010 -> as addi, AluOp=4; lw 100011 -> addi + MemRead; sw 101011 -> AluOp=2, MemWrite, imm_en; beq 000100 -> AluOp=3, Branch; j 000010 -> PCSrc=1; jal 000011 -> PCSrc=1, RegDst=2, DataC, RegWrite.
- R-type func specials (no RegWrite unless stated): jr 001000 -> PCSrc=2; mult 011000, multu 011001, div 011010, divu 011011 -> md issue; mfhi 010000 / mflo 010010 -> RegWrite, RegDst=0, hilo_rd=1/2.
- Any other opcode, valid -> bubble control word, illegal_o=1.
- Bubble = all control outputs 0.
- FSM states: IDLE, MUL_BUSY, DIV_BUSY; counter cnt.
- IDLE + issued mult/multu: md_start_o=1, cnt<=MUL_LAT-1, -> MUL_BUSY (div likewise, DIV_LAT). If LAT=1, stays IDLE.
- BUSY: cnt decrements each cycle; at cnt==0 -> IDLE.
- stall_o=1 when busy and ID holds a valid mul/div/mfhi/mflo, unless flush_i. Stalled instruction registers as bubble; it issues in the cycle the FSM is IDLE.
- Issued = instr_valid_i & ~flush_i & ~stall_o & ~hold_i.
- Independent instructions proceed while busy.
- flush_i: control register loads bubble; sequencer unaffected (in-flight op completes).
- hold_i: control register and illegal_o hold; no md issue; sequencer still counts.

## Timing
- Reset (async, rst_n low): all control outputs, md_start_o, illegal_o = 0; state IDLE, cnt 0; md_busy_o 0. stall_o follows combinationally (0 with no valid input).
- Control word latency: 1 clock (ID at edge N visible at EX after edge N).
- md_start_o registered, high exactly one cycle, aligned with the issuing control word.
- md_busy_o high for exactly LAT cycles after the issue edge.
- mfhi directly after mult: stalls LAT cycles, issues on the next.
- Simultaneous flush_i and stall condition: flush wins, stall_o=0, bubble.
- Reset mid-operation aborts sequencer to IDLE immediately.

## Test plan
- Reset then decode sweep: lw (100011) -> next cycle RegWrite=1, RegDst=1, MemRead=1, imm_en=1, AluOp=2; jal -> PCSrc=2'b01, RegDst=2, DataC=1.
- mult then mflo back-to-back, MUL_LAT=4 -> md_start 1 cycle, md_op=0; stall_o high 4 cycles; mflo issues with hilo_rd=2.
- div then add then mfhi, DIV_LAT=32 -> add issues unstalled; mfhi stalls until md_busy_o falls.
- opcode 111111 valid -> illegal_o=1, bubble; flush_i with mfhi under stall -> stall_o=0, bubble.
- hold_i for 3 cycles during DIV_BUSY -> outputs frozen, cnt still decrements, busy ends on schedule.
- rst_n low mid MUL_BUSY -> md_busy_o=0 and outputs 0 immediately, no clock edge needed.
